led_blink_arbiter: RTL



---
 rtl/led_arb_pkg.sv | 25 ++
 rtl/led_tick_gen.sv | 23 ++
 rtl/led_blink_arbiter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/led_arb_pkg.sv
// Shared types, widths and the round-robin pick helper for the LED blink arbiter.
package led_arb_pkg;

  typedef enum logic [1:0] {IDLE, ON, OFF, GAP} state_t;

  localparam int TICK_W  = 8;
  localparam int CNT_W   = 8;
  localparam int MAX_REQ = 8;

  // One-hot grant for the first valid index at or after (ptr+1) mod n.
  // Scanning from the far end lets the nearest candidate overwrite the rest.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                 input logic [2:0]         ptr,
                                                 input int                 n);
    logic [MAX_REQ-1:0] g;
    int idx;
    g = '0;
    for (int k = n; k >= 1; k--) begin
      idx = (int'(ptr) + k) % n;
      if (valid[idx]) g = MAX_REQ'(1) << idx;
    end
    return g;
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Prescaler: counts 0..TICK_DIV-1 and flags a tick on the last count; clear restarts the phase.
module led_tick_gen #(
  parameter int TICK_DIV = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int W = $clog2(TICK_DIV);

  logic [W-1:0] cnt;

  assign tick = (cnt == W'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || clear) cnt <= '0;
    else if (tick)       cnt <= '0;
    else                 cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/led_blink_arbiter.sv
// Round-robin sharing of one LED between NUM_REQ blink-burst requesters.
// Optional idle heartbeat is enabled by defining LED_ARB_HEARTBEAT_EN.
module led_blink_arbiter
  import led_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int TICK_DIV  = 1000000,
  parameter int GAP_TICKS = 16,
  parameter int HB_TICKS  = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*8-1:0]       req_half,
  input  logic [NUM_REQ*8-1:0]       req_count,
  output logic [NUM_REQ-1:0]         done,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       led
);

  localparam int ID_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_num_req
    $error("NUM_REQ out of range");
  end
  if (TICK_DIV < 2 || HB_TICKS < 1) begin : g_bad_timing
    $error("TICK_DIV or HB_TICKS out of range");
  end

  state_t             state, state_nx;
  logic [TICK_W-1:0]  half_q, tick_cnt, sel_half;
  logic [CNT_W-1:0]   remain, sel_count;
  logic [MAX_REQ-1:0] pick_w;
  logic [NUM_REQ-1:0] pick, done_q;
  logic [ID_W-1:0]    pick_id;
  logic               tick, hs, phase_end, gap_end, end_off;

  led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (state_nx != state),
    .tick  (tick)
  );

  assign pick_w = rr_pick(MAX_REQ'(req_valid), 3'(grant_id), NUM_REQ);
  assign pick   = pick_w[NUM_REQ-1:0];

  always_comb begin
    pick_id = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (pick[i]) pick_id = ID_W'(i);
  end

  assign sel_half  = req_half[int'(pick_id)*8 +: 8];
  assign sel_count = req_count[int'(pick_id)*8 +: 8];
  assign req_ready = (state == IDLE) ? pick : '0;
  assign hs        = (state == IDLE) && (|pick);

  always_comb begin
    state_nx  = state;
    end_off   = 1'b0;
    phase_end = tick && (tick_cnt == half_q - TICK_W'(1));
    gap_end   = tick && (tick_cnt == TICK_W'(GAP_TICKS - 1));
    case (state)
      IDLE: if (hs && sel_count != '0) state_nx = ON;
      ON:   if (phase_end) state_nx = OFF;
      OFF:
        if (phase_end) begin
          if (remain == CNT_W'(1)) begin
            end_off  = 1'b1;
            state_nx = (GAP_TICKS == 0) ? IDLE : GAP;
          end else begin
            state_nx = ON;
          end
        end
      GAP:  if (gap_end) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant_id <= '0;
      half_q   <= TICK_W'(1);
      remain   <= '0;
      tick_cnt <= '0;
      done_q   <= '0;
    end else begin
      state  <= state_nx;
      done_q <= '0;
      if (hs) begin
        grant_id <= pick_id;
        half_q   <= (sel_half == '0) ? TICK_W'(1) : sel_half;
        remain   <= sel_count;
        // Zero-length bursts complete immediately, without touching the LED.
        if (sel_count == '0) done_q <= pick;
      end
      if (state == OFF && phase_end) remain <= remain - CNT_W'(1);
      if (state_nx != state)               tick_cnt <= '0;
      else if (tick && state != IDLE)      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  assign done = done_q | (end_off ? (NUM_REQ'(1) << grant_id) : '0);
  assign busy = (state != IDLE);

`ifdef LED_ARB_HEARTBEAT_EN
  logic [TICK_W-1:0] hb_cnt;
  logic              hb_led;

  // Heartbeat phase only advances while idle and unrequested, so it resumes where it left off.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hb_cnt <= '0;
      hb_led <= 1'b0;
    end else if (state == IDLE && !(|req_valid) && tick) begin
      if (hb_cnt == TICK_W'(HB_TICKS - 1)) begin
        hb_cnt <= '0;
        hb_led <= ~hb_led;
      end else begin
        hb_cnt <= hb_cnt + TICK_W'(1);
      end
    end
  end

  assign led = (state == ON) || (state == IDLE && hb_led && !(|req_valid));
`else
  assign led = (state == ON);
`endif

endmodule
